// File: rtl/sio_host_if.sv
// Link-side and fabric-side signal bundle for sio_host; master is the host view,
// slave is the view of the fabric/pin wrapper that faces it.
interface sio_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  tx;
    logic        oe;
    logic [1:0]  rx;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic        adc_first;
    logic        resp_valid;
    logic [3:0]  resp_addr;
    logic [15:0] resp_data;
    logic [7:0]  err_count;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, rx,
        output cmd_ready, tx, oe, adc_data, adc_valid, adc_first,
               resp_valid, resp_addr, resp_data, err_count
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, rx,
        input  cmd_ready, tx, oe, adc_data, adc_valid, adc_first,
               resp_valid, resp_addr, resp_data, err_count
    );
endinterface

// File: rtl/sio_host.sv
// Host initiator for the 2-bit/clock half-duplex DDR ADC link: sends start + 20-bit command,
// then captures 24 ADC bytes and a 16-bit readback. Optional idle check: SIO_HOST_IDLE_CHECK_EN.
module sio_host #(
    parameter int         FRAME_LEN = 128,
    parameter int         RX_START  = 14,
    parameter logic [3:0] IDLE_ADDR = 4'hF
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      enable,
    sio_host_if.master bus
);
    localparam logic [7:0] LAST_C   = 8'(FRAME_LEN - 1);
    localparam logic [7:0] RX_FIRST = 8'(RX_START);
    localparam logic [7:0] RX_LAST  = 8'(RX_START + 103);
    localparam logic [7:0] TX_LAST  = 8'd10;

    if (FRAME_LEN < 121 || FRAME_LEN > 255) begin : g_bad_frame_len
        $error("sio_host: FRAME_LEN out of range 121..255");
    end
    if (RX_START < 1 || RX_START + 104 > FRAME_LEN) begin : g_bad_rx_start
        $error("sio_host: RX_START+104 exceeds FRAME_LEN");
    end
    if (IDLE_ADDR < 4'd4) begin : g_bad_idle_addr
        $error("sio_host: IDLE_ADDR must be 4..15");
    end

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [19:0] shift;
    logic [3:0]  addr_q;
    logic [5:0]  rx_sr;
    logic [7:0]  resp_hi;
    logic        cmd_hold;
    logic [1:0]  tx_q;
    logic        oe_q;
    logic [7:0]  adc_data_q;
    logic        adc_valid_q;
    logic        adc_first_q;
    logic        resp_valid_q;
    logic [3:0]  resp_addr_q;
    logic [15:0] resp_data_q;

    logic        accept;
    logic [19:0] cmd_word;
    logic [6:0]  rx_idx;
    logic        in_rx;
    logic [7:0]  rx_byte;
    logic [4:0]  rx_group;
    logic        group_done;

    // cmd_hold blocks re-acceptance of a request still held high after its handshake
    assign accept     = !reset && (cnt == '0) && enable && bus.cmd_valid && !cmd_hold;
    assign cmd_word   = accept ? {bus.cmd_addr, bus.cmd_wdata} : {IDLE_ADDR, 16'h0000};
    assign rx_idx     = 7'(cnt - RX_FIRST);
    assign in_rx      = (state == ST_RUN) && (cnt >= RX_FIRST) && (cnt <= RX_LAST);
    assign rx_byte    = {rx_sr, bus.rx};
    assign rx_group   = rx_idx[6:2];
    assign group_done = in_rx && (rx_idx[1:0] == 2'b11);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shift        <= '0;
            addr_q       <= '0;
            rx_sr        <= '0;
            resp_hi      <= '0;
            cmd_hold     <= 1'b0;
            tx_q         <= '0;
            oe_q         <= 1'b0;
            adc_data_q   <= '0;
            adc_valid_q  <= 1'b0;
            adc_first_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            adc_valid_q  <= 1'b0;
            adc_first_q  <= 1'b0;
            resp_valid_q <= 1'b0;

            if (!bus.cmd_valid)
                cmd_hold <= 1'b0;
            else if (accept)
                cmd_hold <= 1'b1;

            if (cnt == '0) begin
                if (enable) begin
                    state  <= ST_RUN;
                    cnt    <= 8'd1;
                    shift  <= cmd_word;
                    addr_q <= cmd_word[19:16];
                    tx_q   <= 2'b00;
                    oe_q   <= 1'b1;
                end else begin
                    state  <= ST_IDLE;
                    tx_q   <= 2'b11;
                    oe_q   <= 1'b0;
                end
            end else begin
                cnt <= (cnt == LAST_C) ? '0 : cnt + 8'd1;
                if (cnt <= TX_LAST) begin
                    tx_q  <= shift[19:18];
                    oe_q  <= 1'b1;
                    shift <= {shift[17:0], 2'b00};
                end else begin
                    tx_q  <= 2'b11;
                    oe_q  <= 1'b0;
                end
                if (in_rx) begin
                    rx_sr <= rx_byte[5:0];
                    if (group_done) begin
                        if (rx_group < 5'd24) begin
                            adc_data_q  <= rx_byte;
                            adc_valid_q <= 1'b1;
                            adc_first_q <= (rx_group == 5'd0);
                        end else if (rx_group == 5'd24) begin
                            resp_hi <= rx_byte;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_addr_q  <= addr_q;
                            resp_data_q  <= {resp_hi, rx_byte};
                        end
                    end
                end
            end
        end
    end

`ifdef SIO_HOST_IDLE_CHECK_EN
    logic [7:0] err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_q <= '0;
        else if (group_done && rx_group == 5'd25 && addr_q == IDLE_ADDR &&
                 {resp_hi, rx_byte} != {12'hAAA, IDLE_ADDR} && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

    assign bus.cmd_ready  = accept;
    assign bus.tx         = tx_q;
    assign bus.oe         = oe_q;
    assign bus.adc_data   = adc_data_q;
    assign bus.adc_valid  = adc_valid_q;
    assign bus.adc_first  = adc_first_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.resp_data  = resp_data_q;
endmodule
